// File: rtl/fx_frame_accumulator.sv
// fx_frame_accumulator
// Sums LEN consecutive valid signed products into one frame result, then
// rounds (half toward +inf), arithmetically shifts by OUT_SHIFT and
// saturates to OUT_W bits. The sample counter is the only frame state:
// count == 0 means idle, anything else means a partial frame is held.
module fx_frame_accumulator #(
    parameter int DATA_W    = 12,
    parameter int LEN       = 8,
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 3,
    parameter int OUT_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_sat,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] count_r;
    logic             o_valid_r;
    logic [OUT_W-1:0] o_data_r;
    logic             o_sat_r;

    logic [ACC_W-1:0] data_ext_s;
    logic [ACC_W-1:0] sum_s;
    logic [ACC_W:0]   rnd_s;
    logic [OUT_W-1:0] sat_data_s;
    logic             sat_flag_s;

    // Clip a rounded ACC_W+1 bit value to OUT_W bits; MSB of result is the clip flag.
    function automatic logic [OUT_W:0] saturate(input logic [ACC_W:0] v);
        logic [ACC_W-OUT_W+1:0] upper;
        upper = v[ACC_W:OUT_W-1];
        if ((&upper) || !(|upper)) begin
            return {1'b0, v[OUT_W-1:0]};
        end else if (v[ACC_W]) begin
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    // Sign-extend the sample and form the running sum (fresh load when idle).
    always_comb begin
        data_ext_s = {{(ACC_W-DATA_W){i_data[DATA_W-1]}}, i_data};
        if (count_r == CNT_ZERO) begin
            sum_s = data_ext_s;
        end else begin
            sum_s = acc_r + data_ext_s;
        end
    end

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
            // Round half toward +inf at ACC_W+1 bits, then arithmetic shift.
            always_comb begin
                rnd_s = $signed({sum_s[ACC_W-1], sum_s} + HALF) >>> OUT_SHIFT;
            end
        end else begin : g_no_round
            // No shift: pass the sign-extended sum straight through.
            always_comb begin
                rnd_s = {sum_s[ACC_W-1], sum_s};
            end
        end
    endgenerate

    // Saturate the rounded frame result to the output range.
    always_comb begin
        {sat_flag_s, sat_data_s} = saturate(rnd_s);
    end

    // Frame accumulation, sample counting and registered result output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_r     <= {ACC_W{1'b0}};
            count_r   <= CNT_ZERO;
            o_valid_r <= 1'b0;
            o_data_r  <= {OUT_W{1'b0}};
            o_sat_r   <= 1'b0;
        end else begin
            o_valid_r <= 1'b0;
            if (i_valid) begin
                if (i_start) begin
                    // Explicit start wins, even on the final position.
                    acc_r   <= data_ext_s;
                    count_r <= CNT_ONE;
                end else if (count_r == CNT_LAST) begin
                    acc_r     <= {ACC_W{1'b0}};
                    count_r   <= CNT_ZERO;
                    o_valid_r <= 1'b1;
                    o_data_r  <= sat_data_s;
                    o_sat_r   <= sat_flag_s;
                end else begin
                    acc_r   <= sum_s;
                    count_r <= count_r + CNT_ONE;
                end
            end else begin
                acc_r   <= acc_r;
                count_r <= count_r;
            end
        end
    end

    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_sat   = o_sat_r;
    assign o_busy  = (count_r != CNT_ZERO);

endmodule

// File: tb/tb_fx_frame_accumulator.sv
// Directed bench for fx_frame_accumulator: two instances (OUT_SHIFT=2 and
// OUT_SHIFT=0, LEN=4, ACC_W=16) share one stimulus stream.
module tb_fx_frame_accumulator;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_valid = 1'b0;
    logic              i_start = 1'b0;
    logic [11:0]       i_data = 12'd0;

    logic              v2, s2, b2;
    logic [11:0]       d2;
    logic              v0, s0, b0;
    logic [11:0]       d0;

    int checks = 0;
    int errors = 0;

    fx_frame_accumulator #(.DATA_W(12), .LEN(4), .ACC_W(16), .OUT_SHIFT(2), .OUT_W(12)) u2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_start(i_start), .i_data(i_data),
        .o_valid(v2), .o_data(d2), .o_sat(s2), .o_busy(b2)
    );

    fx_frame_accumulator #(.DATA_W(12), .LEN(4), .ACC_W(16), .OUT_SHIFT(0), .OUT_W(12)) u0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_start(i_start), .i_data(i_data),
        .o_valid(v0), .o_data(d0), .o_sat(s0), .o_busy(b0)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the rising edge.
    task automatic step(input logic v, input logic s, input int d);
        i_valid = v;
        i_start = s;
        i_data  = 12'(d);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0);
    endtask

    initial begin
        #1;
        // Reset held two cycles with valid samples present
        i_rst = 1'b1;
        step(1'b1, 1'b0, 5);
        chk("rst1_valid", v2, 0); chk("rst1_data", $signed(d2), 0);
        chk("rst1_sat", s2, 0);   chk("rst1_busy", b2, 0);
        step(1'b1, 1'b0, 5);
        chk("rst2_valid", v2, 0); chk("rst2_busy", b2, 0);
        chk("rst2_valid0", v0, 0); chk("rst2_data0", $signed(d0), 0);
        i_rst = 1'b0;

        // Basic frame, shift 2: 1000 -> 250
        step(1'b1, 1'b0, 100);
        chk("basic_busy1", b2, 1); chk("basic_nov1", v2, 0);
        step(1'b1, 1'b0, 200);
        step(1'b1, 1'b0, 300);
        chk("basic_nov3", v2, 0);
        step(1'b1, 1'b0, 400);
        chk("basic_valid", v2, 1); chk("basic_data", $signed(d2), 250);
        chk("basic_sat", s2, 0);   chk("basic_busy_end", b2, 0);
        idle();
        chk("basic_pulse_end", v2, 0); chk("basic_hold", $signed(d2), 250);

        // Rounding, shift 2
        step(1'b1, 1'b0, 1); step(1'b1, 1'b0, 1); step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 0);
        chk("rnd_p2_valid", v2, 1); chk("rnd_p2", $signed(d2), 1);
        step(1'b1, 1'b0, -1); step(1'b1, 1'b0, -1); step(1'b1, 1'b0, -1); step(1'b1, 1'b0, 0);
        chk("rnd_m3_valid", v2, 1); chk("rnd_m3", $signed(d2), -1);
        step(1'b1, 1'b0, -2); step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 0);
        chk("rnd_m2_valid", v2, 1); chk("rnd_m2", $signed(d2), 0);

        // Saturation, shift 0
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2047);
        chk("satp_valid", v0, 1); chk("satp_data", $signed(d0), 2047); chk("satp_flag", s0, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, -2048);
        chk("satn_valid", v0, 1); chk("satn_data", $signed(d0), -2048); chk("satn_flag", s0, 1);
        step(1'b1, 1'b0, 1000); step(1'b1, 1'b0, 1000); step(1'b1, 1'b0, 47); step(1'b1, 1'b0, 0);
        chk("edge_valid", v0, 1); chk("edge_data", $signed(d0), 2047); chk("edge_flag", s0, 0);

        // Gaps inside a frame, then back-to-back frame
        step(1'b1, 1'b0, 10);
        idle(); idle(); idle();
        chk("gap_busy", b0, 1); chk("gap_nov", v0, 0);
        step(1'b1, 1'b0, 20); step(1'b1, 1'b0, 30);
        chk("gap_nov2", v0, 0);
        step(1'b1, 1'b0, 40);
        chk("gap_valid", v0, 1); chk("gap_data", $signed(d0), 100);
        step(1'b1, 1'b0, 1);
        chk("b2b_nov1", v0, 0); chk("b2b_busy", b0, 1);
        step(1'b1, 1'b0, 2);
        step(1'b1, 1'b0, 3);
        chk("b2b_nov3", v0, 0);
        step(1'b1, 1'b0, 4);
        chk("b2b_valid", v0, 1); chk("b2b_data", $signed(d0), 10);

        // Restart mid-frame discards partial 5,5
        step(1'b1, 1'b0, 5); step(1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 7);
        chk("rs_nov", v0, 0);
        step(1'b1, 1'b0, 1); step(1'b1, 1'b0, 1);
        chk("rs_nov2", v0, 0);
        step(1'b1, 1'b0, 1);
        chk("rs_valid", v0, 1); chk("rs_data", $signed(d0), 10);

        // Start on the final-position sample restarts the frame
        step(1'b1, 1'b0, 1); step(1'b1, 1'b0, 1); step(1'b1, 1'b0, 1);
        step(1'b1, 1'b1, 3);
        chk("rsl_nov", v0, 0); chk("rsl_busy", b0, 1);
        step(1'b1, 1'b0, 3); step(1'b1, 1'b0, 3); step(1'b1, 1'b0, 3);
        chk("rsl_valid", v0, 1); chk("rsl_data", $signed(d0), 12);

        // Reset mid-frame discards partial 9,9
        step(1'b1, 1'b0, 9); step(1'b1, 1'b0, 9);
        i_rst = 1'b1;
        step(1'b1, 1'b0, 9);
        i_rst = 1'b0;
        chk("mrst_busy", b0, 0); chk("mrst_nov", v0, 0); chk("mrst_data", $signed(d0), 0);
        step(1'b1, 1'b0, 2); step(1'b1, 1'b0, 2); step(1'b1, 1'b0, 2);
        chk("mrst_nov2", v0, 0);
        step(1'b1, 1'b0, 2);
        chk("mrst_valid", v0, 1); chk("mrst_out", $signed(d0), 8); chk("mrst_sat", s0, 0);
        idle();
        chk("mrst_end", v0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_frame_accumulator.md
Name: fx_frame_accumulator

Overview:
- Downstream consumer of the signed fixed-point multiplier stage.
- Takes the multiplier's registered product stream (two's-complement, DATA_W bits) with a valid strobe.
- Sums LEN consecutive valid products per frame, then emits one result per frame.
- The result is rounded, right-shifted by OUT_SHIFT and saturated to OUT_W bits, with an overflow flag.
- Forms the accumulate half of the datapath's multiply-accumulate (dot-product) stage.

Parameters:
- DATA_W, 12, width of signed input product.
- LEN, 8, number of valid samples per frame (>= 2).
- ACC_W, 20, accumulator width; must be >= DATA_W + clog2(LEN), so the accumulator never wraps.
- OUT_SHIFT, 3, arithmetic right shift applied to the final sum (0 allowed).
- OUT_W, 12, width of signed output.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  i_data is a sample this cycle.
- i_start  input  1  qualified by i_valid; marks the sample as the first of a new frame.
- i_data  input  DATA_W  signed two's-complement product.
- o_valid  output  1  one-cycle pulse, o_data/o_sat valid.
- o_data  output  OUT_W  signed frame result.
- o_sat  output  1  result was clipped; meaningful only with o_valid.
- o_busy  output  1  high while a partial frame is held (count != 0).

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - acc=0, count=0, o_valid=0, o_data=0, o_sat=0, o_busy=0.
  - Reset overrides all inputs in that cycle.
  - Reset mid-frame discards the partial sum; no o_valid is produced for it.
- State: accumulator acc[ACC_W], sample counter count in 0..LEN-1. No other FSM. The counter is the frame state: IDLE when count==0, ACCUM otherwise.
- Cycle with i_valid=0: acc and count hold; o_valid=0. Gaps inside a frame are allowed and unlimited.
- Cycle with i_valid=1 and i_start=1:
  - acc <= sext(i_data); count <= 1.
  - Any partial frame is discarded silently, with no output.
- Cycle with i_valid=1, i_start=0, count < LEN-1:
  - acc <= acc + sext(i_data); count <= count+1.
  - When count==0 this starts a frame implicitly; acc is loaded, not added to a stale value.
- Cycle with i_valid=1, i_start=0, count == LEN-1 (final sample):
  - sum = acc + sext(i_data).
  - Next cycle: o_valid=1 and o_data = sat(rnd(sum)).
  - Same edge: acc <= 0, count <= 0.
- Latency: o_valid rises exactly 1 cycle after the final sample is accepted.
- Throughput: back-to-back frames with no gap are supported. A sample in the cycle o_valid is high belongs to the next frame.
- i_start=1 on the final-position sample: i_start wins. The frame restarts with count=1 and no output.
- LEN is counted in valid samples only, never in cycles.
- Rounding:
  - If OUT_SHIFT>0, rnd(s) = (s + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half toward +inf, arithmetic shift.
  - If OUT_SHIFT=0, rnd(s) = s.
  - The rounding add is done at ACC_W+1 bits so it cannot overflow.
- Saturation:
  - Clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - o_sat=1 exactly when clipping occurred.
- Between pulses: o_data and o_sat hold their last values while o_valid=0.
- The result is computed combinationally from sum and registered into o_data/o_sat/o_valid; the output is fully registered.
- o_busy is combinational from count (count != 0).

Test Plan (LEN=4, DATA_W=12, OUT_W=12, ACC_W=16 unless stated):
- Reset: hold i_rst 2 cycles with i_valid=1 -> o_valid=0, o_data=0, o_sat=0, o_busy=0 throughout.
- Basic frame, OUT_SHIFT=2: valid samples 100, 200, 300, 400 on consecutive cycles -> one cycle after 400, o_valid=1 for 1 cycle, o_data=250, o_sat=0; o_busy high after the first sample, low after the fourth.
- Rounding, OUT_SHIFT=2:
  - Frame 1, 1, 0, 0 (sum 2) -> o_data=1.
  - Frame -1, -1, -1, 0 (sum -3) -> o_data=-1.
  - Frame -2, 0, 0, 0 (sum -2) -> o_data=0.
- Saturation, OUT_SHIFT=0:
  - 2047 ×4 -> o_data=2047, o_sat=1.
  - -2048 ×4 -> o_data=-2048, o_sat=1.
  - 1000, 1000, 47, 0 -> o_data=2047, o_sat=0.
- Gaps and back-to-back:
  - Samples 10, 20 with 3 idle cycles between them, then 30, 40 (OUT_SHIFT=0) -> o_data=100.
  - Immediately next frame 1, 2, 3, 4 with no gap -> o_data=10, pulses exactly 4 valid samples apart.
- Restart and reset mid-frame (OUT_SHIFT=0):
  - 5, 5, then i_start with 7, then 1, 1, 1 -> single output o_data=10; no output for the partial 5, 5.
  - 9, 9, then i_rst for 1 cycle, then 2, 2, 2, 2 -> single output o_data=8.
